// File: rtl/sincro_pkg.sv
// Shared definitions for the frame-alignment controller: lock states and
// default parameter values.
package sincro_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } estado_t;

  localparam int N_DEF       = 4;
  localparam int WORDS_DEF   = 8;
  localparam int CONFIRM_DEF = 2;
  localparam int MISS_DEF    = 2;
  localparam int ERRW_DEF    = 8;

endpackage

// File: rtl/sincronizador_trama_serie_paralelo.sv
// Serial-to-parallel shift register with word-boundary bit counter.
// The look-ahead value o_sr_next lets the FSM compare on the completing bit.
module serie_paralelo
  import sincro_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clear,
  input  logic         i_bit,
  output logic [N-1:0] o_sr_next,
  output logic         o_word_done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [N-1:0]  r_sr;
  logic [CW-1:0] r_bit_cnt;

  // Newest bit enters at the MSB so the first-received bit ends at bit 0.
  assign o_sr_next   = i_en ? {i_bit, r_sr[N-1:1]} : r_sr;
  assign o_word_done = i_en && (r_bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_en) r_sr <= o_sr_next;
      if (i_clear) begin
        r_bit_cnt <= '0;
      end else if (i_en) begin
        r_bit_cnt <= o_word_done ? '0 : r_bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sincronizador_trama.sv
// Frame-alignment controller: hunts the sync word, confirms it over several
// frames, then emits aligned payload words with pattern-match flags.
module sincronizador_trama
  import sincro_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int CONFIRM = CONFIRM_DEF,
  parameter int MISS    = MISS_DEF,
  parameter int ERRW    = ERRW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_bit_valid,
  input  logic            i_entrada_serie,
  input  logic            i_resync,
  input  logic [N-1:0]    i_patron_sync,
  input  logic [N-1:0]    i_patron_A,
  input  logic [N-1:0]    i_patron_B,
  input  logic [N-1:0]    i_patron_C,
  output logic [N-1:0]    o_out_par,
  output logic            o_word_valid,
  output logic            o_out_A,
  output logic            o_out_B,
  output logic            o_out_C,
  output logic            o_frame_start,
  output logic            o_sync_lock,
  output logic [1:0]      o_estado,
  output logic [ERRW-1:0] o_err_count
);

  localparam int WIW = $clog2(WORDS);
  localparam int CFW = $clog2(CONFIRM + 1);
  localparam int MSW = $clog2(MISS + 1);
  localparam logic [WIW-1:0]  LAST_IDX = WIW'(WORDS - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  estado_t        r_state, w_state_next;
  logic [WIW-1:0] r_word_idx, w_word_idx_next;
  logic [CFW-1:0] r_confirm, w_confirm_next;
  logic [MSW-1:0] r_miss, w_miss_next;
  logic [ERRW-1:0] r_err, w_err_next;
  logic [N-1:0]   r_par, w_par_next;
  logic           r_A, r_B, r_C, w_A_next, w_B_next, w_C_next;
  logic           r_wv, r_fs, w_wv_next, w_fs_next;

  logic [N-1:0]   w_sr_next;
  logic           w_word_done;
  logic           w_clear;
  logic           w_sync_hit;
  logic           w_slot0;

  serie_paralelo #(.N(N)) u_serie_paralelo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_bit_valid),
    .i_clear    (w_clear),
    .i_bit      (i_entrada_serie),
    .o_sr_next  (w_sr_next),
    .o_word_done(w_word_done)
  );

  assign w_sync_hit = (w_sr_next == i_patron_sync);
  assign w_slot0    = (r_word_idx == '0);

  always_comb begin
    w_state_next    = r_state;
    w_word_idx_next = r_word_idx;
    w_confirm_next  = r_confirm;
    w_miss_next     = r_miss;
    w_err_next      = r_err;
    w_par_next      = r_par;
    w_A_next        = r_A;
    w_B_next        = r_B;
    w_C_next        = r_C;
    w_wv_next       = 1'b0;
    w_fs_next       = 1'b0;
    w_clear         = 1'b0;

    if (w_word_done) begin
      w_word_idx_next = (r_word_idx == LAST_IDX) ? '0 : r_word_idx + WIW'(1);
    end

    if (i_resync) begin
      w_state_next   = HUNT;
      w_confirm_next = '0;
      w_miss_next    = '0;
      w_clear        = 1'b1;
    end else if (i_bit_valid) begin
      case (r_state)
        HUNT: begin
          // The sync word just seen occupies slot 0; the next word is slot 1.
          if (w_sync_hit) begin
            w_clear         = 1'b1;
            w_word_idx_next = WIW'(1);
            w_confirm_next  = CFW'(1);
            if (CONFIRM == 1) begin
              w_state_next = LOCKED;
              w_miss_next  = '0;
              w_fs_next    = 1'b1;
            end else begin
              w_state_next = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (w_word_done && w_slot0) begin
            if (!w_sync_hit) begin
              w_state_next = HUNT;
            end else if (int'(r_confirm) + 1 >= CONFIRM) begin
              w_state_next = LOCKED;
              w_miss_next  = '0;
              w_fs_next    = 1'b1;
            end else begin
              w_confirm_next = r_confirm + CFW'(1);
            end
          end
        end
        LOCKED: begin
          if (w_word_done) begin
            if (!w_slot0) begin
              w_wv_next  = 1'b1;
              w_par_next = w_sr_next;
              w_A_next   = (w_sr_next == i_patron_A);
              w_B_next   = (w_sr_next == i_patron_B);
              w_C_next   = (w_sr_next == i_patron_C);
            end else if (w_sync_hit) begin
              w_miss_next = '0;
              w_fs_next   = 1'b1;
            end else begin
              // A lone miss keeps the current alignment; only MISS in a row drops it.
              w_miss_next = r_miss + MSW'(1);
              if (r_err != ERR_MAX) w_err_next = r_err + ERRW'(1);
              if (int'(r_miss) + 1 >= MISS) w_state_next = HUNT;
            end
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_word_idx <= '0;
      r_confirm  <= '0;
      r_miss     <= '0;
      r_err      <= '0;
      r_par      <= '0;
      r_A        <= 1'b0;
      r_B        <= 1'b0;
      r_C        <= 1'b0;
      r_wv       <= 1'b0;
      r_fs       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_word_idx <= w_word_idx_next;
      r_confirm  <= w_confirm_next;
      r_miss     <= w_miss_next;
      r_err      <= w_err_next;
      r_par      <= w_par_next;
      r_A        <= w_A_next;
      r_B        <= w_B_next;
      r_C        <= w_C_next;
      r_wv       <= w_wv_next;
      r_fs       <= w_fs_next;
    end
  end

  assign o_out_par     = r_par;
  assign o_word_valid  = r_wv;
  assign o_out_A       = r_A;
  assign o_out_B       = r_B;
  assign o_out_C       = r_C;
  assign o_frame_start = r_fs;
  assign o_sync_lock   = (r_state == LOCKED);
  assign o_estado      = r_state;
  assign o_err_count   = r_err;

endmodule

// File: tb/tb_sincronizador_trama.sv
// Self-checking bench for sincronizador_trama: directed lock/miss/resync
// scenarios plus a randomized frame stream, checked against a frame-level model.
module tb_sincronizador_trama;

  localparam int TN       = 4;
  localparam int TWORDS   = 4;
  localparam int TCONFIRM = 2;
  localparam int TMISS    = 2;
  localparam int TERRW    = 3;
  localparam logic [TN-1:0] SYNC = 4'b1010;

  logic clk = 1'b0;
  logic rst_n;
  logic bitValid = 1'b0;
  logic entrada = 1'b0;
  logic resync = 1'b0;
  logic [TN-1:0] pSync = SYNC;
  logic [TN-1:0] pA = 4'b0011;
  logic [TN-1:0] pB = 4'b1100;
  logic [TN-1:0] pC = 4'b0101;

  logic [TN-1:0]    outPar;
  logic             wordValid, outA, outB, outC, frameStart, syncLock;
  logic [1:0]       estado;
  logic [TERRW-1:0] errCount;

  int nChecks = 0;
  int nFails  = 0;

  sincronizador_trama #(
    .N(TN), .WORDS(TWORDS), .CONFIRM(TCONFIRM), .MISS(TMISS), .ERRW(TERRW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_bit_valid    (bitValid),
    .i_entrada_serie(entrada),
    .i_resync       (resync),
    .i_patron_sync  (pSync),
    .i_patron_A     (pA),
    .i_patron_B     (pB),
    .i_patron_C     (pC),
    .o_out_par      (outPar),
    .o_word_valid   (wordValid),
    .o_out_A        (outA),
    .o_out_B        (outB),
    .o_out_C        (outC),
    .o_frame_start  (frameStart),
    .o_sync_lock    (syncLock),
    .o_estado       (estado),
    .o_err_count    (errCount)
  );

  always #5 clk = ~clk;

  // Expected outputs produced by the reference model
  int            mMode, mPos, mGood, mBad, mErr;
  logic [TN-1:0] mWin, mPar;
  logic          mWv, mFs, mA, mB, mC;

  // Frame-level reference: mode 0/1/2 = hunting/verifying/locked, mPos counts
  // valid bits since the end of the sync word that set the alignment.
  always @(posedge clk or negedge rst_n) begin : refModel
    int mode, pos, good, bad, err, slot;
    logic [TN-1:0] win, par;
    logic wv, fs, a, b, c;
    if (!rst_n) begin
      mMode <= 0; mPos <= 0; mGood <= 0; mBad <= 0; mErr <= 0;
      mWin <= '0; mPar <= '0; mWv <= 0; mFs <= 0; mA <= 0; mB <= 0; mC <= 0;
    end else begin
      mode = mMode; pos = mPos; good = mGood; bad = mBad; err = mErr;
      win = mWin; par = mPar; a = mA; b = mB; c = mC; wv = 0; fs = 0;
      if (bitValid) win = TN'((int'(win) >> 1) + (int'(entrada) << (TN - 1)));
      if (resync) begin
        mode = 0; good = 0; bad = 0;
      end else if (bitValid) begin
        if (mode == 0) begin
          if (win == pSync) begin
            pos = 0; good = 1;
            if (good >= TCONFIRM) begin mode = 2; bad = 0; fs = 1; end
            else mode = 1;
          end
        end else begin
          pos++;
          if (pos % TN == 0) begin
            slot = (pos / TN) % TWORDS;
            if (mode == 1) begin
              if (slot == 0) begin
                if (win == pSync) begin
                  good++;
                  if (good >= TCONFIRM) begin mode = 2; bad = 0; fs = 1; end
                end else mode = 0;
              end
            end else if (slot != 0) begin
              wv = 1; par = win; a = (win == pA); b = (win == pB); c = (win == pC);
            end else if (win == pSync) begin
              bad = 0; fs = 1;
            end else begin
              bad++;
              if (err < (1 << TERRW) - 1) err++;
              if (bad >= TMISS) mode = 0;
            end
          end
        end
      end
      mMode <= mode; mPos <= pos; mGood <= good; mBad <= bad; mErr <= err;
      mWin <= win; mPar <= par; mWv <= wv; mFs <= fs; mA <= a; mB <= b; mC <= c;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every out-of-reset cycle the DUT must agree with the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("estado", 32'(estado), 32'(mMode));
      checkOutput("sync_lock", 32'(syncLock), 32'(mMode == 2));
      checkOutput("word_valid", 32'(wordValid), 32'(mWv));
      checkOutput("frame_start", 32'(frameStart), 32'(mFs));
      checkOutput("out_par", 32'(outPar), 32'(mPar));
      checkOutput("out_A", 32'(outA), 32'(mA));
      checkOutput("out_B", 32'(outB), 32'(mB));
      checkOutput("out_C", 32'(outC), 32'(mC));
      checkOutput("err_count", 32'(errCount), 32'(mErr));
    end
  end

  // Record emitted payload words and whether lock/valid were ever seen
  logic [TN+2:0] capQ[$];
  logic [TN+2:0] refQ[$];
  bit sawLock, sawWv;
  always @(negedge clk) begin
    if (wordValid) begin
      capQ.push_back({outPar, outA, outB, outC});
      sawWv = 1;
    end
    if (syncLock) sawLock = 1;
  end

  task automatic applyStimulus(input logic bv, input logic d, input logic rs);
    @(negedge clk);
    bitValid = bv;
    entrada  = d;
    resync   = rs;
  endtask

  task automatic sendWord(input logic [TN-1:0] w, input int maxIdle, input int rsRate);
    for (int i = 0; i < TN; i++) begin
      int k;
      k = $urandom_range(maxIdle, 0);
      repeat (k) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, w[i], (rsRate != 0) && (($urandom % rsRate) == 0));
    end
  endtask

  logic [TN-1:0] pay [3] = '{4'b0011, 4'b1100, 4'b0101};
  logic [2:0]    payFlags [3] = '{3'b100, 3'b010, 3'b001};

  task automatic sendPayload(input int maxIdle);
    for (int j = 0; j < 3; j++) sendWord(pay[j], maxIdle, 0);
  endtask

  task automatic lockUp();
    sendWord(SYNC, 0, 0);
    sendPayload(0);
    sendWord(SYNC, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; bitValid = 1'b0; resync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_estado"}, 32'(estado), 0);
    checkOutput({tag, "_lock"}, 32'(syncLock), 0);
    checkOutput({tag, "_wv"}, 32'(wordValid), 0);
    checkOutput({tag, "_fs"}, 32'(frameStart), 0);
    checkOutput({tag, "_par"}, 32'(outPar), 0);
    checkOutput({tag, "_abc"}, 32'({outA, outB, outC}), 0);
    checkOutput({tag, "_err"}, 32'(errCount), 0);
  endtask

  // Junk bits, then two frames; literal expectations for every milestone
  task automatic runFrames(input int maxIdle);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = $urandom_range(maxIdle, 0);
      repeat (k) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    sendWord(SYNC, maxIdle, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("verify_entry", 32'(estado), 1);
    sendPayload(maxIdle);
    sendWord(SYNC, maxIdle, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lock_estado", 32'(estado), 2);
    checkOutput("lock_fs", 32'(frameStart), 1);
    checkOutput("lock_sync_lock", 32'(syncLock), 1);
    for (int j = 0; j < 3; j++) begin
      sendWord(pay[j], maxIdle, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("payload_wv", 32'(wordValid), 1);
      checkOutput("payload_par", 32'(outPar), 32'(pay[j]));
      checkOutput("payload_abc", 32'({outA, outB, outC}), 32'(payFlags[j]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] lock sequence with back-to-back bits");
    capQ.delete();
    runFrames(0);
    refQ = capQ;

    $display("[TB] single and double sync misses");
    sendWord(4'b0000, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("miss1_err", 32'(errCount), 1);
    checkOutput("miss1_lock", 32'(syncLock), 1);
    sendPayload(0);
    sendWord(4'b0000, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("miss2_estado", 32'(estado), 0);
    checkOutput("miss2_lock", 32'(syncLock), 0);
    checkOutput("miss2_err", 32'(errCount), 2);

    $display("[TB] error counter saturation");
    lockUp();
    for (int i = 0; i < 11; i++) begin
      sendPayload(0);
      sendWord(4'b0000, 0, 0);
      sendPayload(0);
      sendWord(SYNC, 0, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sat_err", 32'(errCount), 7);
    checkOutput("sat_estado", 32'(estado), 2);

    $display("[TB] resync on a completing payload bit");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resync_wv", 32'(wordValid), 0);
    checkOutput("resync_estado", 32'(estado), 0);
    checkOutput("resync_err", 32'(errCount), 7);

    $display("[TB] asynchronous reset while locked");
    lockUp();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prereset_lock", 32'(syncLock), 1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    sendWord(SYNC, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rehunt_estado", 32'(estado), 1);

    $display("[TB] failed confirmation");
    doReset();
    sawLock = 0; sawWv = 0;
    sendWord(SYNC, 0, 0);
    sendPayload(0);
    sendWord(4'b0000, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("badconf_estado", 32'(estado), 0);
    checkOutput("badconf_sawLock", 32'(sawLock), 0);
    checkOutput("badconf_sawWv", 32'(sawWv), 0);

    $display("[TB] lock sequence with idle gaps");
    doReset();
    capQ.delete();
    runFrames(3);
    checkOutput("gap_seq_len", 32'(capQ.size()), 32'(refQ.size()));
    for (int i = 0; i < refQ.size() && i < capQ.size(); i++)
      checkOutput("gap_seq_word", 32'(capQ[i]), 32'(refQ[i]));

    $display("[TB] randomized frame stream");
    doReset();
    for (int f = 0; f < 80; f++) begin
      logic [TN-1:0] w;
      if ($urandom % 8 == 0) applyStimulus(1'b1, 1'($urandom), 1'b0);
      if ($urandom % 10 == 0) pC = TN'($urandom);
      w = ($urandom % 6 == 0) ? TN'($urandom) : SYNC;
      sendWord(w, 2, 120);
      for (int j = 1; j < TWORDS; j++) sendWord(TN'($urandom), 2, 120);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sincronizador_trama.md
Name: sincronizador_trama

Overview:
Frame-alignment controller for the serial-to-parallel pattern-matching path. It hunts for a programmable sync word in the serial bit stream, confirms it over several frames, and then sequences word-boundary deserialisation. Payload words are compared against patterns A/B/C. It sits between the serial line front-end and the downstream pattern consumers, and replaces free-running bit counting with an aligned, lock-supervised word clocking.

Parameters:
N, 4, word width in bits (≥2)
WORDS, 8, words per frame including the sync word at slot 0 (≥2)
CONFIRM, 2, consecutive correct syncs required to declare lock (≥1)
MISS, 2, consecutive missed syncs that drop lock (≥1)
ERRW, 8, width of saturating sync-error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bit_valid  in  1  entrada_serie is sampled on this cycle
entrada_serie  in  1  serial data bit
resync  in  1  force return to HUNT
patron_sync  in  N  sync word
patron_A / patron_B / patron_C  in  N  match patterns
out_par  out  N  last completed payload word, registered
word_valid  out  1  1-cycle pulse: out_par/out_A..C are valid
out_A / out_B / out_C  out  1  out_par == patron_X, registered with word_valid
frame_start  out  1  1-cycle pulse on an accepted sync word while LOCKED
sync_lock  out  1  high in LOCKED
estado  out  2  HUNT=0, VERIFY=1, LOCKED=2
err_count  out  ERRW  saturating count of missed syncs while LOCKED

Behaviour:
- Reset (async, rst_n=0): all outputs 0, shift register 0, counters 0, estado=HUNT.
- Shift: on bit_valid, sr_next = {entrada_serie, sr[N-1:1]}. The first-received bit ends at bit 0. All comparisons use sr_next.
- With bit_valid=0, all state holds. word_valid and frame_start are forced to 0.
- Word completes on the bit_valid cycle where bit_cnt==N-1. On that cycle bit_cnt wraps to 0 and word_idx increments mod WORDS. Slot 0 is the sync slot.
- HUNT:
  - sync_lock=0.
  - On every valid bit, if sr_next==patron_sync: go to VERIFY, bit_cnt=0, word_idx=1, confirm=1.
  - Otherwise stay; counters are don't-care.
- VERIFY:
  - Counts bits and words; no word_valid is produced.
  - At completion of slot 0, if sr_next==patron_sync: confirm++. If confirm reaches CONFIRM, go to LOCKED with miss=0. If CONFIRM==1, HUNT goes directly to LOCKED.
  - Mismatch at slot 0: go to HUNT.
- LOCKED, at each word completion:
  - Payload slot (word_idx≠0): next cycle word_valid=1, out_par=sr_next, out_X=(sr_next==patron_X).
  - Sync slot, match: miss=0, frame_start=1 next cycle.
  - Sync slot, mismatch: miss++ and err_count++ (saturates at 2^ERRW-1, no wrap). If miss==MISS, go to HUNT and sync_lock falls next cycle.
  - Alignment is kept across a single miss, i.e. no bit slip.
- Latency: outputs update exactly 1 clk after the bit_valid cycle that completes the word.
- out_par and out_A..C hold between word_valid pulses.
- resync=1 has priority over everything. Next cycle: estado=HUNT, confirm/miss cleared, pending pulses suppressed. err_count is retained.
- Pattern inputs are sampled only at comparison time. A change takes effect at the next comparison.
- err_count is cleared only by reset.

Decomposition:
- Shared package sincro_pkg: state encoding constants (HUNT/VERIFY/LOCKED) and default parameter values.
- One sub-module, serie_paralelo: shift register plus bit counter. It exposes sr_next and word_done, with enable=bit_valid and clear=resync or HUNT entry.
- The FSM, word counter, confirm/miss counters and output registers stay in the top module.

Test Plan:
- All cases use N=4, WORDS=4, CONFIRM=2, MISS=2, patron_sync=4'b1010 (sent LSB first: 0,1,0,1), patron_A=4'b0011.
1. Reset mid-stream with rst_n low while LOCKED -> all outputs 0 and estado=0 in the same cycle (asynchronous). After release, the block re-hunts.
2. Send 3 junk bits, then two frames [1010,0011,1100,0101] -> VERIFY after the first sync, LOCKED plus frame_start on the second sync. Then word_valid×3 with out_par=0011 (out_A=1), 1100, 0101.
3. Lock attempt where the second frame's sync slot holds 0000 -> returns to HUNT. sync_lock never rises and word_valid never pulses.
4. While LOCKED, corrupt one sync -> err_count=1 and lock held; corrupt two consecutive syncs -> HUNT, sync_lock=0, err_count=2. Also force 2^ERRW+5 misses (ERRW=3) and confirm err_count saturates at 7.
5. Repeat scenario 2 with 0–3 random idle cycles between bits -> identical out_par/out_X sequence, only delayed.
6. Assert resync on the same cycle as a completing payload bit_valid -> no word_valid, estado=HUNT next cycle, err_count unchanged.
